// File: rtl/decode_hazard_stage_if.sv
// Decode-stage bus: fetch inputs, writeback port, EX load info and ID outputs.
// master = pipeline control/testbench side, slave = decode stage.
interface decode_hazard_stage_if #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int IMM_W = 16,
   parameter int CNT_W = 16
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic              stall_i;
   logic              flush_i;
   logic              if_valid_i;
   logic [5:0]        if_opcode_i;
   logic [5:0]        if_funct_i;
   logic [AW-1:0]     if_rs1_i;
   logic [AW-1:0]     if_rs2_i;
   logic [AW-1:0]     if_rd_i;
   logic [IMM_W-1:0]  if_imm_i;
   logic [XLEN-1:0]   if_pc4_i;
   logic              wb_we_i;
   logic [AW-1:0]     wb_addr_i;
   logic [XLEN-1:0]   wb_data_i;
   logic              ex_load_i;
   logic [AW-1:0]     ex_rd_i;

   logic              id_valid_o;
   logic [5:0]        id_opcode_o;
   logic [5:0]        id_funct_o;
   logic [AW-1:0]     id_rs1_o;
   logic [AW-1:0]     id_rs2_o;
   logic [AW-1:0]     id_rd_o;
   logic [IMM_W-1:0]  id_imm_o;
   logic [XLEN-1:0]   id_pc4_o;
   logic [XLEN-1:0]   id_rdata1_o;
   logic [XLEN-1:0]   id_rdata2_o;
   logic              hazard_stall_o;
   logic [CNT_W-1:0]  hazard_count_o;

   modport master (
      output stall_i, flush_i, if_valid_i, if_opcode_i, if_funct_i, if_rs1_i, if_rs2_i,
             if_rd_i, if_imm_i, if_pc4_i, wb_we_i, wb_addr_i, wb_data_i, ex_load_i, ex_rd_i,
      input  id_valid_o, id_opcode_o, id_funct_o, id_rs1_o, id_rs2_o, id_rd_o, id_imm_o,
             id_pc4_o, id_rdata1_o, id_rdata2_o, hazard_stall_o, hazard_count_o
   );

   modport slave (
      input  stall_i, flush_i, if_valid_i, if_opcode_i, if_funct_i, if_rs1_i, if_rs2_i,
             if_rd_i, if_imm_i, if_pc4_i, wb_we_i, wb_addr_i, wb_data_i, ex_load_i, ex_rd_i,
      output id_valid_o, id_opcode_o, id_funct_o, id_rs1_o, id_rs2_o, id_rd_o, id_imm_o,
             id_pc4_o, id_rdata1_o, id_rdata2_o, hazard_stall_o, hazard_count_o
   );
endinterface

// File: rtl/decode_hazard_stage.sv
// DLX decode stage: IF/ID register, R0-zero register file with optional WB bypass,
// load-use hazard detection against EX and a saturating hazard-cycle counter.
module decode_hazard_stage #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int IMM_W  = 16,
   parameter bit BYPASS = 1'b1,
   parameter int CNT_W  = 16
) (
   input logic                  clk_i,
   input logic                  rst_i,
   decode_hazard_stage_if.slave bus
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic              v_q;
   logic [5:0]        opcode_q, funct_q;
   logic [AW-1:0]     rs1_q, rs2_q, rd_q;
   logic [IMM_W-1:0]  imm_q;
   logic [XLEN-1:0]   pc4_q;
   logic [XLEN-1:0]   rf_q [NREG];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              hazard;
   logic              capture;
   logic [XLEN-1:0]   rdata1, rdata2;

   assign hazard = v_q & bus.ex_load_i & (bus.ex_rd_i != '0) &
                   ((bus.ex_rd_i == rs1_q) | (bus.ex_rd_i == rs2_q));

   // Flush always reloads the fields; otherwise stall or hazard freezes the register.
   assign capture = bus.flush_i | ~(bus.stall_i | hazard);

   always_comb begin
      cnt_d = cnt_q;
      if (hazard && !bus.stall_i && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_q      <= 1'b0;
         opcode_q <= '0;
         funct_q  <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         imm_q    <= '0;
         pc4_q    <= '0;
         cnt_q    <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (capture) begin
            v_q      <= bus.if_valid_i & ~bus.flush_i;
            opcode_q <= bus.if_opcode_i;
            funct_q  <= bus.if_funct_i;
            rs1_q    <= bus.if_rs1_i;
            rs2_q    <= bus.if_rs2_i;
            rd_q     <= bus.if_rd_i;
            imm_q    <= bus.if_imm_i;
            pc4_q    <= bus.if_pc4_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (bus.wb_we_i && (bus.wb_addr_i != '0)) begin
         rf_q[bus.wb_addr_i] <= bus.wb_data_i;
      end
   end

   always_comb begin
      rdata1 = rf_q[rs1_q];
      rdata2 = rf_q[rs2_q];
      if (rs1_q == '0) rdata1 = '0;
      else if (BYPASS && bus.wb_we_i && (bus.wb_addr_i == rs1_q)) rdata1 = bus.wb_data_i;
      if (rs2_q == '0) rdata2 = '0;
      else if (BYPASS && bus.wb_we_i && (bus.wb_addr_i == rs2_q)) rdata2 = bus.wb_data_i;
   end

   assign bus.id_valid_o     = v_q & ~hazard;
   assign bus.id_opcode_o    = opcode_q;
   assign bus.id_funct_o     = funct_q;
   assign bus.id_rs1_o       = rs1_q;
   assign bus.id_rs2_o       = rs2_q;
   assign bus.id_rd_o        = rd_q;
   assign bus.id_imm_o       = imm_q;
   assign bus.id_pc4_o       = pc4_q;
   assign bus.id_rdata1_o    = rdata1;
   assign bus.id_rdata2_o    = rdata2;
   assign bus.hazard_stall_o = hazard;
   assign bus.hazard_count_o = cnt_q;
endmodule

// File: tb/tb_decode_hazard_stage.sv
// Bench for decode_hazard_stage: directed table, saturation/reset sequence, random vs model.
// Two DUTs share stimulus: d1 (BYPASS=1, CNT_W=16) and d2 (BYPASS=0, CNT_W=2).
module tb_decode_hazard_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        stall, flush, ifv, we, exl;
   logic [5:0]  opc, fun;
   logic [4:0]  rs1, rs2, rd, wa, exrd;
   logic [15:0] imm;
   logic [31:0] pc4, wd;

   decode_hazard_stage_if #(.XLEN(32), .NREG(32), .IMM_W(16), .CNT_W(16)) b1 ();
   decode_hazard_stage_if #(.XLEN(32), .NREG(32), .IMM_W(16), .CNT_W(2))  b2 ();

   assign b1.stall_i = stall;  assign b2.stall_i = stall;
   assign b1.flush_i = flush;  assign b2.flush_i = flush;
   assign b1.if_valid_i = ifv; assign b2.if_valid_i = ifv;
   assign b1.if_opcode_i = opc; assign b2.if_opcode_i = opc;
   assign b1.if_funct_i = fun; assign b2.if_funct_i = fun;
   assign b1.if_rs1_i = rs1;   assign b2.if_rs1_i = rs1;
   assign b1.if_rs2_i = rs2;   assign b2.if_rs2_i = rs2;
   assign b1.if_rd_i = rd;     assign b2.if_rd_i = rd;
   assign b1.if_imm_i = imm;   assign b2.if_imm_i = imm;
   assign b1.if_pc4_i = pc4;   assign b2.if_pc4_i = pc4;
   assign b1.wb_we_i = we;     assign b2.wb_we_i = we;
   assign b1.wb_addr_i = wa;   assign b2.wb_addr_i = wa;
   assign b1.wb_data_i = wd;   assign b2.wb_data_i = wd;
   assign b1.ex_load_i = exl;  assign b2.ex_load_i = exl;
   assign b1.ex_rd_i = exrd;   assign b2.ex_rd_i = exrd;

   decode_hazard_stage #(.XLEN(32), .NREG(32), .IMM_W(16), .BYPASS(1'b1), .CNT_W(16))
      d1 (.clk_i(clk), .rst_i(rst), .bus(b1));
   decode_hazard_stage #(.XLEN(32), .NREG(32), .IMM_W(16), .BYPASS(1'b0), .CNT_W(2))
      d2 (.clk_i(clk), .rst_i(rst), .bus(b2));

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural view of the ID slot, register file and counters.
   logic        m_v;
   logic [5:0]  m_opc, m_fun;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [15:0] m_imm;
   logic [31:0] m_pc4;
   logic [31:0] m_reg [32];
   int          m_cnt1, m_cnt2;

   function automatic logic m_hazard();
      return m_v && exl && exrd != 0 && (exrd == m_rs1 || exrd == m_rs2);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && we && wa == a) return wd;
      return m_reg[a];
   endfunction

   task automatic model_reset();
      m_v = 0; m_opc = 0; m_fun = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0; m_pc4 = 0;
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_cnt1 = 0; m_cnt2 = 0;
   endtask

   task automatic model_edge();
      logic h;
      h = m_hazard();
      if (h && !stall) begin
         if (m_cnt1 < 65535) m_cnt1++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      if (we && wa != 0) m_reg[wa] = wd;
      if (flush || !(stall || h)) begin
         m_v = ifv && !flush;
         m_opc = opc; m_fun = fun; m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_imm = imm; m_pc4 = pc4;
      end
   endtask

   task automatic model_compare();
      logic h;
      h = m_hazard();
      check("valid1", b1.id_valid_o, m_v && !h);
      check("valid2", b2.id_valid_o, m_v && !h);
      check("hazard1", b1.hazard_stall_o, h);
      check("hazard2", b2.hazard_stall_o, h);
      check("fields1", {b1.id_opcode_o, b1.id_funct_o, b1.id_rs1_o, b1.id_rs2_o, b1.id_rd_o,
                        b1.id_imm_o}, {m_opc, m_fun, m_rs1, m_rs2, m_rd, m_imm});
      check("pc4_1", b1.id_pc4_o, m_pc4);
      check("rdata1_byp", b1.id_rdata1_o, m_read(m_rs1, 1'b1));
      check("rdata2_byp", b1.id_rdata2_o, m_read(m_rs2, 1'b1));
      check("rdata1_nobyp", b2.id_rdata1_o, m_read(m_rs1, 1'b0));
      check("rdata2_nobyp", b2.id_rdata2_o, m_read(m_rs2, 1'b0));
      check("count16", b1.hazard_count_o, m_cnt1);
      check("count2", b2.hazard_count_o, m_cnt2);
   endtask

   // Inputs are set just after a rising edge; outputs checked on the falling edge.
   task automatic step();
      @(negedge clk);
      model_compare();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic st, fl, iv;
      int rs1, rs2;
      logic we;
      int wa;
      logic [31:0] wd;
      logic exl;
      int exrd;
      logic ev, eh;
      int ers1;
      logic [31:0] erd1, erd2;
      int ecnt;
   } vec_t;

   vec_t tbl [17];

   initial begin
      tbl[0]  = '{0,0,0,  0, 0, 1,5,32'hDEADBEEF, 0,0, 0,0, 0, 32'h0,       32'h0,       0};
      tbl[1]  = '{0,0,1,  5, 0, 0,0,32'h0,        0,0, 0,0, 0, 32'h0,       32'h0,       0};
      tbl[2]  = '{0,0,1,  0, 0, 0,0,32'h0,        0,0, 1,0, 5, 32'hDEADBEEF,32'h0,       0};
      tbl[3]  = '{0,0,1,  0, 0, 1,0,32'hFFFFFFFF, 0,0, 1,0, 0, 32'h0,       32'h0,       0};
      tbl[4]  = '{0,0,1,  7, 3, 0,0,32'h0,        0,0, 1,0, 0, 32'h0,       32'h0,       0};
      tbl[5]  = '{0,0,1,  7, 3, 1,7,32'h1234,     0,0, 1,0, 7, 32'h1234,    32'h0,       0};
      tbl[6]  = '{0,0,1,  9,10, 0,0,32'h0,        1,3, 0,1, 7, 32'h1234,    32'h0,       0};
      tbl[7]  = '{0,0,1,  9,10, 0,0,32'h0,        0,3, 1,0, 7, 32'h1234,    32'h0,       1};
      tbl[8]  = '{0,0,1,  0, 0, 0,0,32'h0,        1,0, 1,0, 9, 32'h0,       32'h0,       1};
      tbl[9]  = '{0,0,1,  4, 5, 0,0,32'h0,        1,0, 1,0, 0, 32'h0,       32'h0,       1};
      tbl[10] = '{0,0,1,  6, 6, 0,0,32'h0,        0,4, 1,0, 4, 32'h0,       32'hDEADBEEF,1};
      tbl[11] = '{1,0,1,  1, 2, 0,0,32'h0,        0,0, 1,0, 6, 32'h0,       32'h0,       1};
      tbl[12] = '{1,0,1,  3, 0, 0,0,32'h0,        0,0, 1,0, 6, 32'h0,       32'h0,       1};
      tbl[13] = '{1,0,1,  8, 0, 0,0,32'h0,        0,0, 1,0, 6, 32'h0,       32'h0,       1};
      tbl[14] = '{0,0,1, 11, 0, 0,0,32'h0,        0,0, 1,0, 6, 32'h0,       32'h0,       1};
      tbl[15] = '{1,1,1, 12, 0, 0,0,32'h0,        0,0, 1,0,11, 32'h0,       32'h0,       1};
      tbl[16] = '{0,0,0,  0, 0, 0,0,32'h0,        0,0, 0,0,12, 32'h0,       32'h0,       1};

      stall = 0; flush = 0; ifv = 0; we = 0; exl = 0;
      opc = 0; fun = 0; rs1 = 0; rs2 = 0; rd = 0; wa = 0; exrd = 0; imm = 0; pc4 = 0; wd = 0;
      model_reset();

      #12;
      check("rst_valid", b1.id_valid_o, 1'b0);
      check("rst_hazard", b1.hazard_stall_o, 1'b0);
      check("rst_count", b1.hazard_count_o, 0);
      check("rst_rdata1", b1.id_rdata1_o, 32'h0);
      check("rst_pc4", b1.id_pc4_o, 32'h0);
      @(posedge clk); #1; rst = 0;

      // Directed table (expectations for the bypassing DUT).
      for (int i = 0; i < 17; i++) begin
         stall = tbl[i].st; flush = tbl[i].fl; ifv = tbl[i].iv;
         rs1 = 5'(tbl[i].rs1); rs2 = 5'(tbl[i].rs2); rd = 5'(tbl[i].rs1) ^ 5'd1;
         opc = 6'(i); fun = ~6'(i); imm = 16'(i * 3); pc4 = 32'h1000 + 32'(4 * i);
         we = tbl[i].we; wa = 5'(tbl[i].wa); wd = tbl[i].wd;
         exl = tbl[i].exl; exrd = 5'(tbl[i].exrd);
         @(negedge clk);
         check($sformatf("tbl%0d_valid", i), b1.id_valid_o, tbl[i].ev);
         check($sformatf("tbl%0d_hazard", i), b1.hazard_stall_o, tbl[i].eh);
         check($sformatf("tbl%0d_rs1", i), b1.id_rs1_o, 5'(tbl[i].ers1));
         check($sformatf("tbl%0d_rdata1", i), b1.id_rdata1_o, tbl[i].erd1);
         check($sformatf("tbl%0d_rdata2", i), b1.id_rdata2_o, tbl[i].erd2);
         check($sformatf("tbl%0d_count", i), b1.hazard_count_o, tbl[i].ecnt);
         model_compare();
         @(posedge clk);
         model_edge();
         #1;
      end

      // Long hazard: 2-bit counter saturates at 3.
      stall = 0; flush = 0; we = 0; exl = 0;
      ifv = 1; rs1 = 5'd3; rs2 = 5'd9; rd = 5'd2; opc = 6'h23;
      step();
      ifv = 1; rs1 = 5'd1; rs2 = 5'd1; exl = 1; exrd = 5'd3;
      repeat (5) step();
      @(negedge clk);
      check("sat_count2", b2.hazard_count_o, 2'd3);
      check("sat_count16", b1.hazard_count_o, 6);
      check("sat_rs1_held", b1.id_rs1_o, 5'd3);

      // Reset asserted mid-hazard clears outputs without an edge.
      #2 rst = 1;
      #1;
      check("midrst_valid", b1.id_valid_o, 1'b0);
      check("midrst_hazard", b1.hazard_stall_o, 1'b0);
      check("midrst_count16", b1.hazard_count_o, 0);
      check("midrst_count2", b2.hazard_count_o, 0);
      check("midrst_rs1", b1.id_rs1_o, 5'd0);
      model_reset();
      @(posedge clk); #1; rst = 0;

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 9) == 0);
         ifv   = ($urandom_range(0, 3) != 0);
         opc = 6'($urandom); fun = 6'($urandom);
         rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
         rd = 5'($urandom); imm = 16'($urandom); pc4 = $urandom;
         we = $urandom_range(0, 1) == 1; wa = 5'($urandom_range(0, 7)); wd = $urandom;
         if ($urandom_range(0, 2) == 0) wa = m_rs1;
         exl = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 3))
            0: exrd = m_rs1;
            1: exrd = m_rs2;
            2: exrd = 5'd0;
            default: exrd = 5'($urandom_range(0, 7));
         endcase
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
